// File: rtl/decode_stage_if.sv
// Fetch, write-back and execute-side signals of decode_stage.
// The environment drives the master side; decode_stage uses the slave side.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    localparam int SW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [SW-1:0]   out_shamt;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_opr_a;
    logic [XLEN-1:0] out_opr_b;
    logic [XLEN-1:0] out_rs2_data;
    logic            out_wb_en;
    logic [1:0]      out_wb_sel;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_shamt, out_rd, out_rs1, out_rs2, out_imm, out_opr_a, out_opr_b,
               out_rs2_data, out_wb_en, out_wb_sel, out_mem_rd, out_mem_wr, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_shamt, out_rd, out_rs1, out_rs2, out_imm, out_opr_a, out_opr_b,
               out_rs2_data, out_wb_en, out_wb_sel, out_mem_rd, out_mem_wr, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV32E decode: register file, field/immediate decode, one registered output slot.
// Latency 1 cycle; in_ready drops for a full stalled slot, flush, load-use or write-back conflict.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data instead of stalling.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam int RW = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [SW-1:0]   shamt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [XLEN-1:0] rs2_data;
        logic            wb_en;
        logic [1:0]      wb_sel;
        logic            mem_rd;
        logic            mem_wr;
        logic            illegal;
    } slot_t;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_W;
    endfunction

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    assign inst = bus.in_inst;
    assign opc  = inst[6:0];
    assign rd   = inst[11:7];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];

    logic        known, use_rs1, use_rs2, writes, sel_pc_a, sel_imm_b, is_load, is_store;
    logic [1:0]  wb_sel;
    logic [31:0] imm32;

    always_comb begin
        known     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes    = 1'b0;
        sel_pc_a  = 1'b0;
        sel_imm_b = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        wb_sel    = 2'd0;
        imm32     = '0;
        case (opc)
            OPC_LUI: begin
                writes = 1'b1; sel_imm_b = 1'b1; wb_sel = 2'd3;
                imm32  = {inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                writes = 1'b1; sel_pc_a = 1'b1; sel_imm_b = 1'b1;
                imm32  = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                writes = 1'b1; sel_pc_a = 1'b1; sel_imm_b = 1'b1; wb_sel = 2'd2;
                imm32  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                writes = 1'b1; use_rs1 = 1'b1; sel_imm_b = 1'b1; wb_sel = 2'd2;
                imm32  = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                writes = 1'b1; use_rs1 = 1'b1; sel_imm_b = 1'b1; wb_sel = 2'd1; is_load = 1'b1;
                imm32  = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; sel_imm_b = 1'b1; is_store = 1'b1;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_OPIMM: begin
                writes = 1'b1; use_rs1 = 1'b1; sel_imm_b = 1'b1;
                imm32  = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP: begin
                writes = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    logic illegal;
    assign illegal = !known
                  || (use_rs1 && !in_range(rs1))
                  || (use_rs2 && !in_range(rs2))
                  || (writes  && !in_range(rd));

    // Write-back that actually lands in the file; only these can stall or bypass.
    logic wb_hit;
    assign wb_hit = bus.wb_en && (bus.wb_rd != 5'd0) && in_range(bus.wb_rd);

    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_hit) begin
            rf[bus.wb_rd[RW-1:0]] <= bus.wb_data;
        end
    end

    logic [XLEN-1:0] rs1_data, rs2_data;
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0 && in_range(rs1)) rs1_data = rf[rs1[RW-1:0]];
        if (rs2 != 5'd0 && in_range(rs2)) rs2_data = rf[rs2[RW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_hit && bus.wb_rd == rs1) rs1_data = bus.wb_data;
        if (wb_hit && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
    end

    logic wb_stall;
`ifdef DECODE_WB_BYPASS_EN
    assign wb_stall = 1'b0;
`else
    assign wb_stall = wb_hit && ((use_rs1 && bus.wb_rd == rs1) || (use_rs2 && bus.wb_rd == rs2));
`endif

    slot_t slot_q, slot_d;
    logic  valid_q;
    logic  hazard, in_ready, accept;

    assign hazard = valid_q && slot_q.mem_rd && (slot_q.rd != 5'd0)
                 && ((use_rs1 && slot_q.rd == rs1) || (use_rs2 && slot_q.rd == rs2));
    assign in_ready = (!valid_q || bus.out_ready) && !bus.flush && !hazard && !wb_stall;
    assign accept   = bus.in_valid && in_ready;

    logic [XLEN-1:0] imm;
    assign imm = XLEN'($signed(imm32));

    always_comb begin
        slot_d          = '0;
        slot_d.pc       = bus.in_pc;
        slot_d.opcode   = opc;
        slot_d.funct3   = inst[14:12];
        slot_d.funct7   = inst[31:25];
        slot_d.shamt    = inst[20 +: SW];
        slot_d.rd       = rd;
        slot_d.rs1      = rs1;
        slot_d.rs2      = rs2;
        slot_d.imm      = imm;
        slot_d.opr_a    = sel_pc_a ? bus.in_pc : rs1_data;
        slot_d.opr_b    = sel_imm_b ? imm : rs2_data;
        slot_d.rs2_data = rs2_data;
        slot_d.wb_en    = writes && (rd != 5'd0) && !illegal;
        slot_d.wb_sel   = wb_sel;
        slot_d.mem_rd   = is_load && !illegal;
        slot_d.mem_wr   = is_store && !illegal;
        slot_d.illegal  = illegal;
    end

    // Popping without a refill is what turns a load-use stall into a single bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            slot_q  <= slot_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = slot_q.pc;
    assign bus.out_opcode   = slot_q.opcode;
    assign bus.out_funct3   = slot_q.funct3;
    assign bus.out_funct7   = slot_q.funct7;
    assign bus.out_shamt    = slot_q.shamt;
    assign bus.out_rd       = slot_q.rd;
    assign bus.out_rs1      = slot_q.rs1;
    assign bus.out_rs2      = slot_q.rs2;
    assign bus.out_imm      = slot_q.imm;
    assign bus.out_opr_a    = slot_q.opr_a;
    assign bus.out_opr_b    = slot_q.opr_b;
    assign bus.out_rs2_data = slot_q.rs2_data;
    assign bus.out_wb_en    = slot_q.wb_en;
    assign bus.out_wb_sel   = slot_q.wb_sel;
    assign bus.out_mem_rd   = slot_q.mem_rd;
    assign bus.out_mem_wr   = slot_q.mem_wr;
    assign bus.out_illegal  = slot_q.illegal;
endmodule
